// File: rtl/ram3840_arbiter_if.sv
// ram3840_arbiter_if
// Requester-side command bundle for the two-port RAM arbiter.
//   req0/1, we0/1, addr0/1, wdata0/1 : command from port 0 (CPU) / port 1 (DMA)
//   gnt0/1                            : one-cycle pulse, command accepted
//   done0/1, err0/1                   : one-cycle completion pulse, err valid with done
//   rdata0/1                          : read data, valid with done, held until next done
// Handshake: a requester raises req with we/addr/wdata and holds all of them
// stable until it sees gnt; the command is accepted on the gnt pulse. It then
// waits for done (with err) before raising a new command. gnt and done are
// pulses, never levels, and the arbiter never back-pressures done.
`timescale 1ns/1ps
interface ram3840_arbiter_if;
   logic        req0;
   logic        req1;
   logic        we0;
   logic        we1;
   logic [11:0] addr0;
   logic [11:0] addr1;
   logic [15:0] wdata0;
   logic [15:0] wdata1;
   logic        gnt0;
   logic        gnt1;
   logic        done0;
   logic        done1;
   logic        err0;
   logic        err1;
   logic [15:0] rdata0;
   logic [15:0] rdata1;

   // Requester side
   modport master (
      output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
      input  gnt0, gnt1, done0, done1, err0, err1, rdata0, rdata1
   );

   // Arbiter side
   modport slave (
      input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
      output gnt0, gnt1, done0, done1, err0, err1, rdata0, rdata1
   );
endinterface

// File: rtl/ram3840_arbiter.sv
// ram3840_arbiter
// Round-robin arbiter/sequencer placing two requesters onto the single port of
// the 3840 x 16 banked RAM (NUM_BANKS banks of 256 words, bank = addr[11:8]).
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   cmd          : requester command/response bundle (slave modport)
//   busy         : arbiter not in IDLE
//   mem_addr     : RAM address, held from ACCESS through WAIT
//   mem_in       : RAM write data
//   mem_load     : one-cycle write strobe
//   bank_load    : one-hot bank write enable, decode(addr[11:8]) & mem_load
//   mem_out      : RAM read data, valid RD_LAT cycles after mem_addr
//   dbg_state    : current FSM state (IDLE=0, ACCESS=1, WAIT=2, RESP=3)
`timescale 1ns/1ps
module ram3840_arbiter #(
   parameter int NUM_BANKS = 15,
   parameter int RD_LAT    = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   ram3840_arbiter_if.slave     cmd,
   output logic                 busy,
   output logic [11:0]          mem_addr,
   output logic [15:0]          mem_in,
   output logic                 mem_load,
   output logic [NUM_BANKS-1:0] bank_load,
   input  logic [15:0]          mem_out,
   output logic [1:0]           dbg_state
);

   typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;

   // Index of the final WAIT cycle; unused when RD_LAT is 0 (WAIT is skipped).
   localparam logic [1:0] LAST_WAIT = 2'((RD_LAT > 0) ? RD_LAT - 1 : 0);

   state_t                 state, state_nx;
   logic                   last_q;     // port granted most recently
   logic                   port_q;     // port owning the command in flight
   logic                   we_q;
   logic                   oor_q;      // command address has no backing bank
   logic [1:0]             wait_cnt;

   logic                   win_valid;
   logic                   win_port;
   logic                   win_we;
   logic                   win_oor;
   logic [11:0]            win_addr;
   logic [15:0]            win_wdata;
   logic [NUM_BANKS-1:0]   win_dec;
   logic                   capture;

   assign busy      = (state != IDLE);
   assign dbg_state = state;

   // Next state, arbitration and read-capture decision.
   always_comb begin
      state_nx  = state;
      win_valid = 1'b0;
      win_port  = 1'b0;
      capture   = 1'b0;
      case (state)
         IDLE: begin
            if (cmd.req0 || cmd.req1) begin
               win_valid = 1'b1;
               // On a tie the port not granted last time wins.
               if (cmd.req0 && cmd.req1) win_port = ~last_q;
               else                      win_port = cmd.req1;
               state_nx = ACCESS;
            end
         end
         ACCESS: begin
            if (we_q || oor_q) begin
               state_nx = RESP;
            end else if (RD_LAT == 0) begin
               capture  = 1'b1;
               state_nx = RESP;
            end else begin
               state_nx = WAIT;
            end
         end
         WAIT: begin
            if (wait_cnt == LAST_WAIT) begin
               capture  = 1'b1;
               state_nx = RESP;
            end
         end
         RESP:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Winning command mux and bank decode.
   always_comb begin
      win_we    = win_port ? cmd.we1    : cmd.we0;
      win_addr  = win_port ? cmd.addr1  : cmd.addr0;
      win_wdata = win_port ? cmd.wdata1 : cmd.wdata0;
      win_oor   = ({1'b0, win_addr[11:8]} >= 5'(NUM_BANKS));
      win_dec   = '0;
      for (int i = 0; i < NUM_BANKS; i++) begin
         win_dec[i] = (win_addr[11:8] == 4'(i));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // All strobes are registered so that reset clears them immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q     <= 1'b1;
         port_q     <= 1'b0;
         we_q       <= 1'b0;
         oor_q      <= 1'b0;
         wait_cnt   <= 2'd0;
         mem_addr   <= '0;
         mem_in     <= '0;
         mem_load   <= 1'b0;
         bank_load  <= '0;
         cmd.gnt0   <= 1'b0;
         cmd.gnt1   <= 1'b0;
         cmd.done0  <= 1'b0;
         cmd.done1  <= 1'b0;
         cmd.err0   <= 1'b0;
         cmd.err1   <= 1'b0;
         cmd.rdata0 <= '0;
         cmd.rdata1 <= '0;
      end else begin
         cmd.gnt0  <= win_valid & ~win_port;
         cmd.gnt1  <= win_valid &  win_port;
         mem_load  <= win_valid & win_we & ~win_oor;
         bank_load <= (win_valid && win_we && !win_oor) ? win_dec : '0;
         if (win_valid) begin
            last_q   <= win_port;
            port_q   <= win_port;
            we_q     <= win_we;
            oor_q    <= win_oor;
            mem_addr <= win_addr;
            mem_in   <= win_wdata;
         end
         wait_cnt  <= (state == WAIT) ? wait_cnt + 2'd1 : 2'd0;
         // RESP is only ever entered from ACCESS or WAIT, so this is a pulse.
         cmd.done0 <= (state_nx == RESP) & ~port_q;
         cmd.done1 <= (state_nx == RESP) &  port_q;
         cmd.err0  <= (state_nx == RESP) & ~port_q & oor_q;
         cmd.err1  <= (state_nx == RESP) &  port_q & oor_q;
         if (capture) begin
            if (port_q) cmd.rdata1 <= mem_out;
            else        cmd.rdata0 <= mem_out;
         end
      end
   end

endmodule

// File: tb/tb_ram3840_arbiter.sv
// tb_ram3840_arbiter
// Bench for ram3840_arbiter: three instances (RD_LAT = 1, 0, 3), each with its
// own RAM model. Directed scenarios plus mixed two-port traffic against a
// reference memory.
`timescale 1ns/1ps
module tb_ram3840_arbiter;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_cmp = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   ram3840_arbiter_if cmd_a ();
   ram3840_arbiter_if cmd_z ();
   ram3840_arbiter_if cmd_t ();

   logic        busy_a, busy_z, busy_t;
   logic [11:0] mem_addr_a, mem_addr_z, mem_addr_t;
   logic [15:0] mem_in_a, mem_in_z, mem_in_t;
   logic        mem_load_a, mem_load_z, mem_load_t;
   logic [14:0] bank_load_a, bank_load_z, bank_load_t;
   logic [15:0] mem_out_a, mem_out_z, mem_out_t;
   logic [1:0]  dbg_a, dbg_z, dbg_t;

   ram3840_arbiter #(.NUM_BANKS(15), .RD_LAT(1)) dut_a (
      .clk(clk), .rst_n(rst_n), .cmd(cmd_a.slave), .busy(busy_a), .mem_addr(mem_addr_a),
      .mem_in(mem_in_a), .mem_load(mem_load_a), .bank_load(bank_load_a),
      .mem_out(mem_out_a), .dbg_state(dbg_a));
   ram3840_arbiter #(.NUM_BANKS(15), .RD_LAT(0)) dut_z (
      .clk(clk), .rst_n(rst_n), .cmd(cmd_z.slave), .busy(busy_z), .mem_addr(mem_addr_z),
      .mem_in(mem_in_z), .mem_load(mem_load_z), .bank_load(bank_load_z),
      .mem_out(mem_out_z), .dbg_state(dbg_z));
   ram3840_arbiter #(.NUM_BANKS(15), .RD_LAT(3)) dut_t (
      .clk(clk), .rst_n(rst_n), .cmd(cmd_t.slave), .busy(busy_t), .mem_addr(mem_addr_t),
      .mem_in(mem_in_t), .mem_load(mem_load_t), .bank_load(bank_load_t),
      .mem_out(mem_out_t), .dbg_state(dbg_t));

   // RAM models: write on mem_load, read data RD_LAT cycles after mem_addr.
   logic [15:0] ram_a [0:4095];
   logic [15:0] ram_z [0:4095];
   logic [15:0] ram_t [0:4095];
   logic [15:0] t_p1, t_p2;
   logic [15:0] exp_mem [0:15];

   initial begin
      for (int i = 0; i < 4096; i++) begin
         ram_a[i] = '0;
         ram_z[i] = '0;
         ram_t[i] = '0;
      end
      for (int i = 0; i < 16; i++) exp_mem[i] = '0;
   end

   always @(posedge clk) begin
      if (mem_load_a) ram_a[mem_addr_a] <= mem_in_a;
      mem_out_a <= ram_a[mem_addr_a];
   end
   always @(posedge clk) begin
      if (mem_load_z) ram_z[mem_addr_z] <= mem_in_z;
   end
   assign mem_out_z = ram_z[mem_addr_z];
   always @(posedge clk) begin
      if (mem_load_t) ram_t[mem_addr_t] <= mem_in_t;
      t_p1      <= ram_t[mem_addr_t];
      t_p2      <= t_p1;
      mem_out_t <= t_p2;
   end

   // Bank strobe monitor on the main instance.
   always @(negedge clk) begin
      if (mem_load_a || bank_load_a != 15'd0) begin
         n_cmp++;
         if (!mem_load_a || mem_addr_a >= 12'hF00 ||
             bank_load_a !== (15'd1 << mem_addr_a[11:8])) begin
            n_fail++;
            $display("FAIL bank_load_mon: got load=%b bank=%h addr=%h", mem_load_a, bank_load_a, mem_addr_a);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic set_req(input int inst, input bit p, input bit r, input bit we,
                          input logic [11:0] a, input logic [15:0] d);
      case (inst)
         0: if (!p) begin
               cmd_a.req0 = r; cmd_a.we0 = we; cmd_a.addr0 = a; cmd_a.wdata0 = d;
            end else begin
               cmd_a.req1 = r; cmd_a.we1 = we; cmd_a.addr1 = a; cmd_a.wdata1 = d;
            end
         1: begin cmd_z.req0 = r; cmd_z.we0 = we; cmd_z.addr0 = a; cmd_z.wdata0 = d; end
         default: begin cmd_t.req0 = r; cmd_t.we0 = we; cmd_t.addr0 = a; cmd_t.wdata0 = d; end
      endcase
   endtask

   function automatic logic get_gnt(input int inst, input bit p);
      case (inst)
         0: return p ? cmd_a.gnt1 : cmd_a.gnt0;
         1: return cmd_z.gnt0;
         default: return cmd_t.gnt0;
      endcase
   endfunction

   function automatic logic get_done(input int inst, input bit p);
      case (inst)
         0: return p ? cmd_a.done1 : cmd_a.done0;
         1: return cmd_z.done0;
         default: return cmd_t.done0;
      endcase
   endfunction

   function automatic logic get_err(input int inst, input bit p);
      case (inst)
         0: return p ? cmd_a.err1 : cmd_a.err0;
         1: return cmd_z.err0;
         default: return cmd_t.err0;
      endcase
   endfunction

   function automatic logic [15:0] get_rdata(input int inst, input bit p);
      case (inst)
         0: return p ? cmd_a.rdata1 : cmd_a.rdata0;
         1: return cmd_z.rdata0;
         default: return cmd_t.rdata0;
      endcase
   endfunction

   function automatic logic get_mem_load(input int inst);
      case (inst)
         0: return mem_load_a;
         1: return mem_load_z;
         default: return mem_load_t;
      endcase
   endfunction

   function automatic logic [14:0] get_bank_load(input int inst);
      case (inst)
         0: return bank_load_a;
         1: return bank_load_z;
         default: return bank_load_t;
      endcase
   endfunction

   task automatic apply_reset();
      set_req(0, 0, 0, 0, 12'h0, 16'h0);
      set_req(0, 1, 0, 0, 12'h0, 16'h0);
      set_req(1, 0, 0, 0, 12'h0, 16'h0);
      set_req(2, 0, 0, 0, 12'h0, 16'h0);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   // Issues one command from a negedge. gl = negedges from raise to gnt,
   // dl = cycles from gnt to done (-1 when not seen in time).
   task automatic run_cmd(input int inst, input bit p, input bit we, input logic [11:0] a,
                          input logic [15:0] d, output int gl, output int dl,
                          output logic ml, output logic [14:0] bl, output logic er,
                          output logic [15:0] rd);
      gl = -1; dl = -1; ml = 1'b0; bl = '0; er = 1'b0; rd = '0;
      set_req(inst, p, 1, we, a, d);
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (gl < 0 && get_gnt(inst, p)) begin
            gl = c;
            ml = get_mem_load(inst);
            bl = get_bank_load(inst);
            set_req(inst, p, 0, we, a, d);
         end
         if (gl >= 0 && get_done(inst, p)) begin
            dl = c - gl;
            er = get_err(inst, p);
            rd = get_rdata(inst, p);
            break;
         end
      end
      set_req(inst, p, 0, we, a, d);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      bit saw_done;
      apply_reset();
      n_cmp++; if ({cmd_a.gnt0, cmd_a.gnt1, cmd_a.done0, cmd_a.done1, cmd_a.err0, cmd_a.err1} !== 6'b0) begin
         n_fail++; $display("FAIL reset_pulses: got %b want 000000",
            {cmd_a.gnt0, cmd_a.gnt1, cmd_a.done0, cmd_a.done1, cmd_a.err0, cmd_a.err1}); end
      n_cmp++; if ({cmd_a.rdata0, cmd_a.rdata1, mem_in_a} !== 48'h0 || mem_addr_a !== 12'h0) begin
         n_fail++; $display("FAIL reset_data: got rdata0=%h rdata1=%h mem_in=%h mem_addr=%h want 0",
            cmd_a.rdata0, cmd_a.rdata1, mem_in_a, mem_addr_a); end
      n_cmp++; if (busy_a !== 1'b0 || dbg_a !== 2'd0 || mem_load_a !== 1'b0 || bank_load_a !== 15'h0) begin
         n_fail++; $display("FAIL reset_ctrl: got busy=%b state=%0d load=%b bank=%h want 0",
            busy_a, dbg_a, mem_load_a, bank_load_a); end
      // Abort a write in its ACCESS cycle.
      set_req(0, 0, 1, 1, 12'h123, 16'hBEEF);
      @(negedge clk);
      n_cmp++; if (mem_load_a !== 1'b1 || cmd_a.gnt0 !== 1'b1) begin
         n_fail++; $display("FAIL abort_access: got load=%b gnt0=%b want 1 1", mem_load_a, cmd_a.gnt0); end
      rst_n = 1'b0;
      set_req(0, 0, 0, 0, 12'h0, 16'h0);
      #1;
      n_cmp++; if (mem_load_a !== 1'b0 || bank_load_a !== 15'h0) begin
         n_fail++; $display("FAIL abort_strobe: got load=%b bank=%h want 0 0", mem_load_a, bank_load_a); end
      saw_done = 1'b0;
      repeat (2) begin
         @(negedge clk);
         if (cmd_a.done0 || cmd_a.done1) saw_done = 1'b1;
      end
      rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         if (cmd_a.done0 || cmd_a.done1) saw_done = 1'b1;
      end
      n_cmp++; if (saw_done !== 1'b0) begin
         n_fail++; $display("FAIL abort_no_done: got %b want 0", saw_done); end
      n_cmp++; if (busy_a !== 1'b0 || cmd_a.gnt0 !== 1'b0 || mem_addr_a !== 12'h0) begin
         n_fail++; $display("FAIL abort_release: got busy=%b gnt0=%b addr=%h want 0", busy_a, cmd_a.gnt0, mem_addr_a); end
      n_cmp++; if (ram_a[12'h123] !== 16'h0) begin
         n_fail++; $display("FAIL abort_commit: got %h want 0000", ram_a[12'h123]); end
   endtask

   task automatic test_write_read();
      int gl, dl; logic ml, er; logic [14:0] bl; logic [15:0] rd;
      @(negedge clk);
      run_cmd(0, 0, 1, 12'h0A5, 16'h1234, gl, dl, ml, bl, er, rd);
      n_cmp++; if (gl !== 1 || dl !== 1) begin
         n_fail++; $display("FAIL wr_timing: got gl=%0d dl=%0d want 1 1", gl, dl); end
      n_cmp++; if (ml !== 1'b1 || bl !== 15'h0001 || er !== 1'b0) begin
         n_fail++; $display("FAIL wr_strobe: got load=%b bank=%h err=%b want 1 0001 0", ml, bl, er); end
      n_cmp++; if (ram_a[12'h0A5] !== 16'h1234) begin
         n_fail++; $display("FAIL wr_commit: got %h want 1234", ram_a[12'h0A5]); end
      // Back-to-back read: raised in the done cycle, so gnt comes 3 cycles after the previous gnt.
      run_cmd(0, 0, 0, 12'h0A5, 16'h0, gl, dl, ml, bl, er, rd);
      n_cmp++; if (gl !== 2 || dl !== 2) begin
         n_fail++; $display("FAIL rd_timing: got gl=%0d dl=%0d want 2 2", gl, dl); end
      n_cmp++; if (rd !== 16'h1234 || ml !== 1'b0 || er !== 1'b0) begin
         n_fail++; $display("FAIL rd_data: got rd=%h load=%b err=%b want 1234 0 0", rd, ml, er); end
   endtask

   task automatic test_tie_alternate();
      int order[$];
      int exp_o[4] = '{0, 1, 0, 1};
      int n0 = 1, n1 = 1, cyc_done0 = -1, cyc_gnt1 = -1;
      apply_reset();
      set_req(0, 0, 1, 1, 12'h010, 16'h1000);
      set_req(0, 1, 1, 1, 12'h020, 16'h2000);
      for (int c = 1; c <= 40 && order.size() < 4; c++) begin
         @(negedge clk);
         if (cmd_a.gnt0) begin order.push_back(0); set_req(0, 0, 0, 1, 12'h010, 16'h1000); end
         if (cmd_a.gnt1) begin
            order.push_back(1); set_req(0, 1, 0, 1, 12'h020, 16'h2000);
            if (cyc_gnt1 < 0) cyc_gnt1 = c;
         end
         if (cmd_a.done0) begin
            if (cyc_done0 < 0) cyc_done0 = c;
            if (n0 < 2) begin n0++; set_req(0, 0, 1, 1, 12'h011, 16'h1001); end
         end
         if (cmd_a.done1 && n1 < 2) begin n1++; set_req(0, 1, 1, 1, 12'h021, 16'h2001); end
      end
      for (int c = 0; c < 10 && busy_a; c++) @(negedge clk);
      @(negedge clk);
      n_cmp++; if (order.size() !== 4) begin
         n_fail++; $display("FAIL tie_count: got %0d grants want 4", order.size()); end
      for (int i = 0; i < 4; i++) begin
         if (i < order.size()) begin
            n_cmp++; if (order[i] !== exp_o[i]) begin
               n_fail++; $display("FAIL tie_order[%0d]: got port %0d want port %0d", i, order[i], exp_o[i]); end
         end
      end
      n_cmp++; if (cyc_gnt1 - cyc_done0 !== 2) begin
         n_fail++; $display("FAIL tie_gnt1_after_done0: got %0d cycles want 2", cyc_gnt1 - cyc_done0); end
      n_cmp++; if (ram_a[12'h021] !== 16'h2001 || ram_a[12'h011] !== 16'h1001) begin
         n_fail++; $display("FAIL tie_commit: got %h %h want 2001 1001", ram_a[12'h021], ram_a[12'h011]); end
   endtask

   task automatic test_bank_edge();
      int gl, dl; logic ml, er; logic [14:0] bl; logic [15:0] rd;
      @(negedge clk);
      run_cmd(0, 1, 1, 12'hEFF, 16'hA5A5, gl, dl, ml, bl, er, rd);
      n_cmp++; if (ml !== 1'b1 || bl !== 15'h4000 || er !== 1'b0 || dl !== 1) begin
         n_fail++; $display("FAIL edge_wr_EFF: got load=%b bank=%h err=%b dl=%0d want 1 4000 0 1", ml, bl, er, dl); end
      run_cmd(0, 1, 0, 12'hEFF, 16'h0, gl, dl, ml, bl, er, rd);
      n_cmp++; if (rd !== 16'hA5A5 || dl !== 2) begin
         n_fail++; $display("FAIL edge_rd_EFF: got rd=%h dl=%0d want a5a5 2", rd, dl); end
      run_cmd(0, 1, 0, 12'hF00, 16'h0, gl, dl, ml, bl, er, rd);
      n_cmp++; if (ml !== 1'b0 || er !== 1'b1 || dl !== 1) begin
         n_fail++; $display("FAIL edge_rd_F00: got load=%b err=%b dl=%0d want 0 1 1", ml, er, dl); end
      n_cmp++; if (rd !== 16'hA5A5) begin
         n_fail++; $display("FAIL edge_rd_F00_hold: got %h want a5a5", rd); end
      run_cmd(0, 1, 1, 12'hFFF, 16'h7777, gl, dl, ml, bl, er, rd);
      n_cmp++; if (ml !== 1'b0 || bl !== 15'h0 || er !== 1'b1 || ram_a[12'hFFF] !== 16'h0) begin
         n_fail++; $display("FAIL edge_wr_FFF: got load=%b bank=%h err=%b ram=%h want 0 0 1 0", ml, bl, er, ram_a[12'hFFF]); end
   endtask

   task automatic test_rd_latency();
      int gl, dl; logic ml, er; logic [14:0] bl; logic [15:0] rd;
      @(negedge clk);
      run_cmd(1, 0, 1, 12'h3C0, 16'h5A5A, gl, dl, ml, bl, er, rd);
      @(negedge clk);
      run_cmd(1, 0, 0, 12'h3C0, 16'h0, gl, dl, ml, bl, er, rd);
      n_cmp++; if (gl !== 1 || dl !== 1 || rd !== 16'h5A5A) begin
         n_fail++; $display("FAIL lat0_read: got gl=%0d dl=%0d rd=%h want 1 1 5a5a", gl, dl, rd); end
      @(negedge clk);
      run_cmd(2, 0, 1, 12'h7FE, 16'hC3C3, gl, dl, ml, bl, er, rd);
      n_cmp++; if (dl !== 1 || bl !== 15'h0080) begin
         n_fail++; $display("FAIL lat3_write: got dl=%0d bank=%h want 1 0080", dl, bl); end
      @(negedge clk);
      run_cmd(2, 0, 0, 12'h7FE, 16'h0, gl, dl, ml, bl, er, rd);
      n_cmp++; if (gl !== 1 || dl !== 4 || rd !== 16'hC3C3) begin
         n_fail++; $display("FAIL lat3_read: got gl=%0d dl=%0d rd=%h want 1 4 c3c3", gl, dl, rd); end
      @(negedge clk);
      run_cmd(2, 0, 0, 12'hF80, 16'h0, gl, dl, ml, bl, er, rd);
      n_cmp++; if (dl !== 1 || er !== 1'b1 || rd !== 16'hC3C3) begin
         n_fail++; $display("FAIL lat3_err: got dl=%0d err=%b rd=%h want 1 1 c3c3", dl, er, rd); end
   endtask

   // One requester of the mixed-traffic scenario. Expectations are taken at
   // gnt time, when every earlier command has already completed.
   task automatic port_proc(input bit p, input int n);
      logic [15:0] last_rd = '0;
      for (int k = 0; k < n; k++) begin
         bit we, oor, got;
         int others;
         logic [11:0] a;
         logic [15:0] d, exp_rd;
         we  = 1'($urandom_range(0, 1));
         oor = ($urandom_range(0, 7) == 0);
         a   = oor ? 12'hF00 + 12'($urandom_range(0, 255)) : 12'h500 + 12'($urandom_range(0, 15));
         d   = 16'($urandom_range(0, 65535));
         exp_rd = last_rd;
         got = 1'b0; others = 0;
         set_req(0, p, 1, we, a, d);
         for (int c = 0; c < 30 && !got; c++) begin
            @(negedge clk);
            if (get_gnt(0, !p)) others++;
            if (get_gnt(0, p)) begin
               got = 1'b1;
               if (!oor) begin
                  if (we) exp_mem[a[3:0]] = d;
                  else    exp_rd = exp_mem[a[3:0]];
               end
            end
         end
         set_req(0, p, 0, we, a, d);
         n_cmp++; if (!got || others > 1) begin
            n_fail++; $display("FAIL rand_p%0d_gnt[%0d]: got gnt=%b others=%0d want 1 <=1", p, k, got, others); end
         if (got) begin
            bit seen = 1'b0;
            for (int c = 0; c < 10 && !seen; c++) begin
               @(negedge clk);
               if (get_done(0, p)) begin
                  seen = 1'b1;
                  n_cmp++; if (get_err(0, p) !== oor || get_rdata(0, p) !== exp_rd) begin
                     n_fail++; $display("FAIL rand_p%0d_resp[%0d]: addr=%h got err=%b rd=%h want %b %h",
                        p, k, a, get_err(0, p), get_rdata(0, p), oor, exp_rd); end
               end
            end
            n_cmp++; if (!seen) begin
               n_fail++; $display("FAIL rand_p%0d_done[%0d]: got no done want done", p, k); end
            last_rd = exp_rd;
         end
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
   endtask

   task automatic test_random();
      apply_reset();
      fork
         port_proc(0, 20);
         port_proc(1, 20);
      join
   endtask

   initial begin
      set_req(0, 0, 0, 0, 12'h0, 16'h0);
      set_req(0, 1, 0, 0, 12'h0, 16'h0);
      set_req(1, 0, 0, 0, 12'h0, 16'h0);
      set_req(2, 0, 0, 0, 12'h0, 16'h0);
      cmd_z.req1 = 1'b0; cmd_z.we1 = 1'b0; cmd_z.addr1 = '0; cmd_z.wdata1 = '0;
      cmd_t.req1 = 1'b0; cmd_t.we1 = 1'b0; cmd_t.addr1 = '0; cmd_t.wdata1 = '0;
      test_reset();
      test_write_read();
      test_tie_alternate();
      test_bank_edge();
      test_rd_latency();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
